ui_screen_router: RTL and testbench

- Parametrised successor to the fixed 4-screen UUID selector in the converter top level.
- Owns the current-screen register, the shared timing-setting bank, and a registered LCD write arbiter.
- Adds behaviour the fixed selector lacks:
  - Automatic two-line LCD clear on every screen switch.
  - Request/ack LCD handshake against lcd_busy.
  - Runtime-writable timing registers for the settings screen.
  - Rejection of invalid screen IDs.

---
 rtl/ui_pkg.sv | 21 ++
 rtl/ui_screen_router_if.sv | 42 ++++
 rtl/ui_timing_regs.sv | 19 +
 rtl/ui_screen_router.sv | 98 +++++++++
 tb/tb_ui_screen_router.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/ui_pkg.sv
// ui_pkg: screen IDs, 50 MHz timing defaults and LCD constants shared by the UI blocks.
package ui_pkg;
  localparam int ID_MAIN = 0;
  localparam int ID_DECODE = 1;
  localparam int ID_ENCODE = 2;
  localparam int ID_SETTING = 3;
  localparam int T_DIT = 0;
  localparam int T_DAH = 1;
  localparam int T_SPACE = 2;
  localparam int T_LONG = 3;
  localparam logic [31:0] DEF_DIT = 32'd5_000_000;
  localparam logic [31:0] DEF_DAH = 32'd15_000_000;
  localparam logic [31:0] DEF_SPACE = 32'd35_000_000;
  localparam logic [31:0] DEF_LONG = 32'd25_000_000;
  localparam int LCD_COLS = 16;
  localparam logic [7:0] SPACE_CHAR = 8'h20;
  typedef enum logic [1:0] {CLR0, CLR1, HOLD, RUN} ui_state_t;
  function automatic logic [31:0] timing_default(input int idx);
    return (idx == T_DIT) ? DEF_DIT : (idx == T_DAH) ? DEF_DAH : (idx == T_SPACE) ? DEF_SPACE : DEF_LONG;
  endfunction
endpackage

// File: rtl/ui_screen_router_if.sv
// ui_screen_router_if: screen request bus, LCD write bus and timing settings port of the router.
interface ui_screen_router_if #(
  parameter int NUM_SCREENS = 4,
  parameter int ID_W = 4,
  parameter int NUM_TIMING = 4,
  parameter int TIME_W = 32,
  parameter int TEXT_W = 128
);
  logic [NUM_SCREENS-1:0] scr_update;
  logic [NUM_SCREENS-1:0][ID_W-1:0] scr_next_id;
  logic [NUM_SCREENS-1:0] scr_lcd_req;
  logic [NUM_SCREENS-1:0][4:0] scr_lcd_x;
  logic [NUM_SCREENS-1:0][1:0] scr_lcd_y;
  logic [NUM_SCREENS-1:0][TEXT_W-1:0] scr_lcd_text;
  logic [NUM_SCREENS-1:0][7:0] scr_lcd_len;
  logic [NUM_SCREENS-1:0] scr_lcd_ack;
  logic lcd_busy;
  logic lcd_write_req;
  logic [4:0] lcd_x_pos;
  logic [1:0] lcd_y_pos;
  logic [TEXT_W-1:0] lcd_text;
  logic [7:0] lcd_text_len;
  logic [ID_W-1:0] cur_id;
  logic [NUM_SCREENS-1:0] active;
  logic id_err;
  logic set_wr;
  logic [1:0] set_idx;
  logic [TIME_W-1:0] set_data;
  logic [NUM_TIMING*TIME_W-1:0] timing;
  modport master (
    output scr_update, scr_next_id, scr_lcd_req, scr_lcd_x, scr_lcd_y, scr_lcd_text, scr_lcd_len,
    output lcd_busy, set_wr, set_idx, set_data,
    input scr_lcd_ack, lcd_write_req, lcd_x_pos, lcd_y_pos, lcd_text, lcd_text_len,
    input cur_id, active, id_err, timing
  );
  modport slave (
    input scr_update, scr_next_id, scr_lcd_req, scr_lcd_x, scr_lcd_y, scr_lcd_text, scr_lcd_len,
    input lcd_busy, set_wr, set_idx, set_data,
    output scr_lcd_ack, lcd_write_req, lcd_x_pos, lcd_y_pos, lcd_text, lcd_text_len,
    output cur_id, active, id_err, timing
  );
endinterface

// File: rtl/ui_timing_regs.sv
// ui_timing_regs: runtime-writable timing bank with 50 MHz reset defaults.
module ui_timing_regs import ui_pkg::*; #(
  parameter int NUM_TIMING = 4,
  parameter int TIME_W = 32
) (
  input  logic clk,
  input  logic rst,
  input  logic i_wr,
  input  logic [1:0] i_idx,
  input  logic [TIME_W-1:0] i_data,
  output logic [NUM_TIMING*TIME_W-1:0] o_timing
);
  localparam int TW = (NUM_TIMING > 1) ? $clog2(NUM_TIMING) : 1;
  logic [NUM_TIMING-1:0][TIME_W-1:0] r_bank;
  always_ff @(posedge clk or posedge rst)
    if (rst) for (int i = 0; i < NUM_TIMING; i++) r_bank[TW'(i)] <= TIME_W'(timing_default(i));
    else if (i_wr && 32'(i_idx) < NUM_TIMING) r_bank[TW'(i_idx)] <= i_data;
  assign o_timing = r_bank;
endmodule

// File: rtl/ui_screen_router.sv
// ui_screen_router: current-screen register, clear-on-switch sequencer and registered LCD write arbiter.
module ui_screen_router import ui_pkg::*; #(
  parameter int NUM_SCREENS = 4,
  parameter int ID_W = 4,
  parameter int HOME_ID = ID_MAIN,
  parameter int NUM_TIMING = 4,
  parameter int TIME_W = 32,
  parameter int TEXT_W = 128
) (
  input logic clk,
  input logic rst,
  ui_screen_router_if.slave bus
);
  localparam int SW = (NUM_SCREENS > 1) ? $clog2(NUM_SCREENS) : 1;
  ui_state_t r_state, w_state;
  logic [ID_W-1:0] r_cur, w_cur, w_next;
  logic r_hold;
  logic w_strobe, w_err, w_upd, w_req, w_free, w_valid;
  logic [SW-1:0] w_sel;
  logic [4:0] w_x;
  logic [1:0] w_y;
  logic [TEXT_W-1:0] w_text;
  logic [7:0] w_len;
  assign w_sel = r_cur[SW-1:0];
  assign w_upd = bus.scr_update[w_sel];
  assign w_next = bus.scr_next_id[w_sel];
  assign w_req = bus.scr_lcd_req[w_sel];
  assign w_valid = 32'(w_next) < NUM_SCREENS;
  // r_hold blanks the cycle after each strobe so a late busy rise is not missed
  assign w_free = !bus.lcd_busy && !r_hold;
  always_comb begin
    w_state = r_state;
    w_cur = r_cur;
    w_strobe = 1'b0;
    w_err = 1'b0;
    w_x = '0;
    w_y = '0;
    w_text = TEXT_W'({LCD_COLS{SPACE_CHAR}});
    w_len = 8'(LCD_COLS);
    case (r_state)
      CLR0, CLR1: if (w_free) begin
        w_strobe = 1'b1;
        w_y = {1'b0, r_state == CLR1};
        w_state = (r_state == CLR0) ? CLR1 : HOLD;
      end
      HOLD: w_state = RUN;
      default: begin
        w_err = w_upd && !w_valid;
        if (w_upd && w_valid && w_next != r_cur) begin
          w_cur = w_next;
          w_state = CLR0;
        end else if (w_req && w_free) begin
          w_strobe = 1'b1;
          w_x = bus.scr_lcd_x[w_sel];
          w_y = bus.scr_lcd_y[w_sel];
          w_text = bus.scr_lcd_text[w_sel];
          w_len = bus.scr_lcd_len[w_sel];
        end
      end
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      r_state <= CLR0;
      r_cur <= ID_W'(HOME_ID);
      r_hold <= 1'b0;
      bus.lcd_write_req <= 1'b0;
      bus.lcd_x_pos <= '0;
      bus.lcd_y_pos <= '0;
      bus.lcd_text <= '0;
      bus.lcd_text_len <= '0;
      bus.scr_lcd_ack <= '0;
      bus.id_err <= 1'b0;
    end else begin
      r_state <= w_state;
      r_cur <= w_cur;
      r_hold <= w_strobe;
      bus.lcd_write_req <= w_strobe;
      bus.id_err <= w_err;
      bus.scr_lcd_ack <= (w_strobe && r_state == RUN) ? NUM_SCREENS'(1) << w_sel : '0;
      if (w_strobe) begin
        bus.lcd_x_pos <= w_x;
        bus.lcd_y_pos <= w_y;
        bus.lcd_text <= w_text;
        bus.lcd_text_len <= w_len;
      end
    end
  assign bus.cur_id = r_cur;
  assign bus.active = (r_state == RUN) ? NUM_SCREENS'(1) << w_sel : '0;
  ui_timing_regs #(.NUM_TIMING(NUM_TIMING), .TIME_W(TIME_W)) u_timing (
    .clk(clk),
    .rst(rst),
    .i_wr(bus.set_wr),
    .i_idx(bus.set_idx),
    .i_data(bus.set_data),
    .o_timing(bus.timing)
  );
endmodule

// File: tb/tb_ui_screen_router.sv
// tb_ui_screen_router: directed stimulus with a line-count screen model compared every cycle.
module tb_ui_screen_router;
  logic clk = 1'b0;
  logic rst;
  int n_pass = 0;
  int n_tot = 0;
  int n;
  ui_screen_router_if bus();
  ui_screen_router dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  // model: clear lines still owed, one settle cycle after clearing, and whether the last cycle strobed
  int m_clr, m_c;
  bit m_settle, m_last, m_s;
  logic [3:0] m_cur, e_ack;
  logic e_wreq, e_err;
  logic [4:0] e_x;
  logic [1:0] e_y;
  logic [127:0] e_text;
  logic [7:0] e_len;
  logic [31:0] e_tim [4];
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_clr = 2; m_settle = 0; m_last = 0; m_cur = 0;
      e_wreq = 0; e_err = 0; e_x = 0; e_y = 0; e_text = 0; e_len = 0; e_ack = 0;
      e_tim = '{32'd5_000_000, 32'd15_000_000, 32'd35_000_000, 32'd25_000_000};
    end else begin
      m_s = 0; m_c = int'(m_cur); e_ack = 0; e_err = 0;
      if (bus.set_wr) e_tim[bus.set_idx] = bus.set_data;
      if (m_clr > 0) begin
        if (!bus.lcd_busy && !m_last) begin
          m_s = 1; e_x = 0; e_y = 2'(2 - m_clr); e_text = {16{8'h20}}; e_len = 16;
          m_clr--;
          m_settle = (m_clr == 0);
        end
      end else if (m_settle) m_settle = 0;
      else begin
        if (bus.scr_update[m_c]) begin
          if (bus.scr_next_id[m_c] >= 4) e_err = 1;
          else if (int'(bus.scr_next_id[m_c]) != m_c) begin
            m_cur = bus.scr_next_id[m_c];
            m_clr = 2;
          end
        end
        if (m_clr == 0 && bus.scr_lcd_req[m_c] && !bus.lcd_busy && !m_last) begin
          m_s = 1;
          e_x = bus.scr_lcd_x[m_c]; e_y = bus.scr_lcd_y[m_c];
          e_text = bus.scr_lcd_text[m_c]; e_len = bus.scr_lcd_len[m_c];
          e_ack = 4'(1 << m_c);
        end
      end
      e_wreq = m_s; m_last = m_s;
    end
  end

  always @(negedge clk) if (!rst) begin
    chk("wreq", bus.lcd_write_req, e_wreq);
    chk("x", bus.lcd_x_pos, e_x);
    chk("y", bus.lcd_y_pos, e_y);
    chk("text", bus.lcd_text, e_text);
    chk("len", bus.lcd_text_len, e_len);
    chk("ack", bus.scr_lcd_ack, e_ack);
    chk("id_err", bus.id_err, e_err);
    chk("cur_id", bus.cur_id, m_cur);
    chk("active", bus.active, (m_clr == 0 && !m_settle) ? 4'(1 << int'(m_cur)) : 4'b0);
    chk("timing", bus.timing, {e_tim[3], e_tim[2], e_tim[1], e_tim[0]});
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic wait_active(input logic [3:0] exp, input int budget, output int strobes);
    strobes = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.lcd_write_req) strobes++;
      if (bus.active == exp) break;
    end
    chk("active_wait", bus.active, exp);
  endtask

  localparam logic [127:0] DEF_T = {32'd25_000_000, 32'd35_000_000, 32'd15_000_000, 32'd5_000_000};
  localparam logic [127:0] SPACES = {16{8'h20}};

  initial begin
    rst = 1'b1;
    bus.scr_update = 0; bus.scr_next_id = 0; bus.scr_lcd_req = 0;
    bus.lcd_busy = 0; bus.set_wr = 0; bus.set_idx = 0; bus.set_data = 0;
    for (int s = 0; s < 4; s++) begin
      bus.scr_lcd_x[s] = 5'(s * 3 + 1);
      bus.scr_lcd_y[s] = 2'(s);
      bus.scr_lcd_text[s] = {16{8'(8'h41 + s)}};
      bus.scr_lcd_len[s] = 8'(s + 5);
    end
    repeat (2) tick();
    chk("rst_cur", bus.cur_id, 4'd0);
    chk("rst_active", bus.active, 4'd0);
    chk("rst_wreq", bus.lcd_write_req, 1'b0);
    chk("rst_timing", bus.timing, DEF_T);
    rst = 1'b0;
    tick();
    chk("clr0_wreq", bus.lcd_write_req, 1'b1);
    chk("clr0_y", bus.lcd_y_pos, 2'd0);
    chk("clr0_text", bus.lcd_text, SPACES);
    chk("clr0_len", bus.lcd_text_len, 8'd16);
    tick();
    chk("holdoff", bus.lcd_write_req, 1'b0);
    tick();
    chk("clr1_wreq", bus.lcd_write_req, 1'b1);
    chk("clr1_y", bus.lcd_y_pos, 2'd1);
    tick();
    chk("home_active", bus.active, 4'b0001);
    // switch 0 -> 2
    bus.scr_update[0] = 1; bus.scr_next_id[0] = 2;
    tick();
    bus.scr_update[0] = 0;
    chk("sw_active_zero", bus.active, 4'b0000);
    chk("sw_cur", bus.cur_id, 4'd2);
    wait_active(4'b0100, 10, n);
    chk("sw_clear_strobes", n, 2);
    // update from an inactive screen
    bus.scr_update[1] = 1; bus.scr_next_id[1] = 3;
    tick();
    bus.scr_update[1] = 0;
    chk("ign_cur", bus.cur_id, 4'd2);
    chk("ign_active", bus.active, 4'b0100);
    // invalid ID
    bus.scr_update[2] = 1; bus.scr_next_id[2] = 9;
    tick();
    bus.scr_update[2] = 0;
    chk("err_pulse", bus.id_err, 1'b1);
    chk("err_cur", bus.cur_id, 4'd2);
    chk("err_no_strobe", bus.lcd_write_req, 1'b0);
    tick();
    chk("err_single", bus.id_err, 1'b0);
    // switch 2 -> 1
    bus.scr_update[2] = 1; bus.scr_next_id[2] = 1;
    tick();
    bus.scr_update[2] = 0;
    wait_active(4'b0010, 10, n);
    // busy held while screen 1 requests; screen 3 also requests but is inactive
    bus.lcd_busy = 1; bus.scr_lcd_req[1] = 1; bus.scr_lcd_req[3] = 1;
    n = 0;
    repeat (20) begin
      tick();
      if (bus.lcd_write_req) n++;
    end
    chk("busy_no_strobe", n, 0);
    bus.lcd_busy = 0;
    tick();
    chk("wr_strobe", bus.lcd_write_req, 1'b1);
    chk("wr_ack", bus.scr_lcd_ack, 4'b0010);
    chk("wr_x", bus.lcd_x_pos, 5'd4);
    chk("wr_y", bus.lcd_y_pos, 2'd1);
    chk("wr_text", bus.lcd_text, {16{8'h42}});
    chk("wr_len", bus.lcd_text_len, 8'd6);
    tick();
    chk("wr_holdoff", bus.lcd_write_req, 1'b0);
    tick();
    chk("wr_second", bus.lcd_write_req, 1'b1);
    bus.scr_lcd_req[1] = 0; bus.scr_lcd_req[3] = 0;
    repeat (2) tick();
    // update and request together: update wins
    bus.scr_update[1] = 1; bus.scr_next_id[1] = 0; bus.scr_lcd_req[1] = 1;
    tick();
    bus.scr_update[1] = 0; bus.scr_lcd_req[1] = 0;
    chk("race_ack", bus.scr_lcd_ack, 4'b0000);
    chk("race_wreq", bus.lcd_write_req, 1'b0);
    chk("race_cur", bus.cur_id, 4'd0);
    // timing write while clearing
    bus.set_wr = 1; bus.set_idx = 1; bus.set_data = 32'd20_000_000;
    tick();
    bus.set_wr = 0;
    chk("tim_slice1", bus.timing[63:32], 32'd20_000_000);
    chk("tim_others", {bus.timing[127:64], bus.timing[31:0]}, {32'd25_000_000, 32'd35_000_000, 32'd5_000_000});
    wait_active(4'b0001, 10, n);
    // reset in the middle of a clear
    bus.scr_update[0] = 1; bus.scr_next_id[0] = 3;
    tick();
    bus.scr_update[0] = 0;
    tick();
    #2 rst = 1'b1;
    #1;
    chk("arst_wreq", bus.lcd_write_req, 1'b0);
    chk("arst_cur", bus.cur_id, 4'd0);
    chk("arst_active", bus.active, 4'd0);
    chk("arst_text", bus.lcd_text, 128'd0);
    chk("arst_len", bus.lcd_text_len, 8'd0);
    chk("arst_timing", bus.timing, DEF_T);
    tick();
    rst = 1'b0;
    wait_active(4'b0001, 6, n);
    chk("arst_clear_strobes", n, 2);
    repeat (2) tick();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
